// File: rtl/eth_rx_addr_filter.sv
// Ethernet RX destination-address filter: buffers the 6-byte destination,
// decides pass/drop, then replays the header and cuts the rest through.
module eth_rx_addr_filter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock50,
    input  logic                   reset,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic                   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic                   m_axis_tready,
    input  logic [47:0]            mac_addr,
    input  logic                   promisc,
    input  logic                   accept_multicast,
    output logic [COUNT_WIDTH-1:0] frames_passed,
    output logic [COUNT_WIDTH-1:0] frames_dropped
);

    typedef enum logic [1:0] {HDR, FLUSH, PASS, DROP} state_t;

    state_t                 r_state;
    logic [2:0]             r_idx;
    logic [5:0][7:0]        r_buf;
    logic                   r_last;
    logic                   r_user;
    logic [COUNT_WIDTH-1:0] r_passed;
    logic [COUNT_WIDTH-1:0] r_dropped;

    logic [47:0] w_dest;
    logic        w_match;
    logic        w_s_hs;
    logic        w_m_hs;
    logic        w_s_ready;
    logic        w_m_valid;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only meaningful when byte 5 is being accepted: bytes 0..4 are buffered.
    assign w_dest  = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], s_axis_tdata};
    assign w_match = promisc || (w_dest == mac_addr) || (&w_dest) ||
                     (accept_multicast && r_buf[0][0]);

    always_comb begin
        w_s_ready    = 1'b0;
        w_m_valid    = 1'b0;
        m_axis_tdata = 8'h00;
        m_axis_tlast = 1'b0;
        m_axis_tuser = 1'b0;
        if (!reset) begin
            case (r_state)
                HDR:   w_s_ready = 1'b1;
                FLUSH: begin
                    w_m_valid    = 1'b1;
                    m_axis_tdata = r_buf[r_idx];
                    if (r_idx == 3'd5) begin
                        m_axis_tlast = r_last;
                        m_axis_tuser = r_user;
                    end
                end
                PASS: begin
                    w_s_ready    = m_axis_tready;
                    w_m_valid    = s_axis_tvalid;
                    m_axis_tdata = s_axis_tdata;
                    m_axis_tlast = s_axis_tlast;
                    m_axis_tuser = s_axis_tuser;
                end
                DROP:    w_s_ready = 1'b1;
                default: w_s_ready = 1'b0;
            endcase
        end
    end

    assign s_axis_tready  = w_s_ready;
    assign m_axis_tvalid  = w_m_valid;
    assign w_s_hs         = s_axis_tvalid && w_s_ready;
    assign w_m_hs         = w_m_valid && m_axis_tready;
    assign frames_passed  = r_passed;
    assign frames_dropped = r_dropped;

    always_ff @(posedge clock50) begin
        if (reset) begin
            r_state   <= HDR;
            r_idx     <= 3'd0;
            r_last    <= 1'b0;
            r_user    <= 1'b0;
            r_passed  <= '0;
            r_dropped <= '0;
        end else begin
            case (r_state)
                HDR: if (w_s_hs) begin
                    r_buf[r_idx] <= s_axis_tdata;
                    r_last       <= s_axis_tlast;
                    r_user       <= s_axis_tuser;
                    if (r_idx == 3'd5) begin
                        r_idx <= 3'd0;
                        if (w_match)           r_state   <= FLUSH;
                        else if (s_axis_tlast) r_dropped <= sat_inc(r_dropped);
                        else                   r_state   <= DROP;
                    end else if (s_axis_tlast) begin
                        // runt: ends before the destination is complete
                        r_idx     <= 3'd0;
                        r_dropped <= sat_inc(r_dropped);
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                FLUSH: if (w_m_hs) begin
                    if (r_idx == 3'd5) begin
                        r_idx <= 3'd0;
                        if (r_last) begin
                            r_state  <= HDR;
                            r_passed <= sat_inc(r_passed);
                        end else begin
                            r_state <= PASS;
                        end
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                PASS: if (w_s_hs && s_axis_tlast) begin
                    r_state  <= HDR;
                    r_passed <= sat_inc(r_passed);
                end
                DROP: if (w_s_hs && s_axis_tlast) begin
                    r_state   <= HDR;
                    r_dropped <= sat_inc(r_dropped);
                end
                default: r_state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Randomised scoreboard bench for eth_rx_addr_filter: the driver predicts each
// frame's fate from the address rules, a monitor checks every output beat.
module tb_eth_rx_addr_filter;
    localparam int CW = 4;
    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC2 = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BC   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MC   = 48'h01_00_5E_00_00_01;

    logic          clock50 = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic          s_axis_tready;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic          m_axis_tready = 1'b1;
    logic [47:0]   mac_addr = MAC;
    logic          promisc = 1'b0, accept_multicast = 1'b0;
    logic [CW-1:0] frames_passed, frames_dropped;

    eth_rx_addr_filter #(.COUNT_WIDTH(CW)) dut (
        .clock50(clock50), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .mac_addr(mac_addr), .promisc(promisc), .accept_multicast(accept_multicast),
        .frames_passed(frames_passed), .frames_dropped(frames_dropped)
    );

    always #10 clock50 = ~clock50;

    typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
    beat_t      exp_q[$];
    logic [7:0] fr[$];
    logic       fr_user;
    int         checks = 0, errors = 0;
    int         mod_pass = 0, mod_drop = 0;
    int         ready_mode = 0;

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    function automatic bit addr_ok(input logic [47:0] dst, input logic [47:0] mac,
                                   input bit pr, input bit am);
        return pr || dst == mac || dst == BC || (am && dst[40]);
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Downstream ready: always 1, or a fair coin each cycle
    initial forever begin
        @(posedge clock50); #1;
        m_axis_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clock50);
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h,%b,%b expected nothing",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} != e) begin
                        errors++;
                        $display("FAIL out_beat got %h,%b,%b expected %h,%b,%b",
                                 m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
                    end
                end
            end
        end
    end

    task automatic build(input logic [47:0] dst, input int len, input logic usr);
        logic [7:0] b;
        fr.delete();
        for (int i = 0; i < len; i++) begin
            b = (i < 6) ? dst[47-8*i -: 8] : 8'($urandom);
            fr.push_back(b);
        end
        fr_user = usr;
    endtask

    // Called and returns at posedge+#1. reset_at >= 0 pulses reset at that byte.
    task automatic send(input bit rnd_cfg, input bit rnd_gap, input int reset_at);
        int len = fr.size();
        bit hs, passed, stall;
        int cnt;
        beat_t b;
        passed = 0; stall = 0;
        for (int i = 0; i < len; i++) begin
            if (i == reset_at) begin
                s_axis_tvalid = 1'b0;
                reset = 1'b1;
                @(negedge clock50);
                check("rst_m_tvalid", int'(m_axis_tvalid), 0);
                check("rst_s_tready", int'(s_axis_tready), 0);
                @(posedge clock50); #1;
                reset = 1'b0;
                exp_q.delete();
                mod_pass = 0; mod_drop = 0;
                @(negedge clock50);
                check("post_rst_m_tvalid", int'(m_axis_tvalid), 0);
                check("post_rst_passed", int'(frames_passed), 0);
                check("post_rst_dropped", int'(frames_dropped), 0);
                @(posedge clock50); #1;
                return;
            end
            if (rnd_gap && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clock50); #1;
            end
            if (rnd_cfg) begin
                mac_addr         = ($urandom_range(0, 1) != 0) ? MAC : MAC2;
                promisc          = ($urandom_range(0, 3) == 0);
                accept_multicast = 1'($urandom_range(0, 1));
            end
            s_axis_tdata  = fr[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = (i == len - 1) && fr_user;
            hs = 0; cnt = 0;
            while (!hs) begin
                @(negedge clock50);
                hs = s_axis_tready;
                if (!hs && i > 5) stall = 1;
                // decision uses the config present when byte 5 is accepted
                if (hs && i == 5 &&
                    addr_ok({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]},
                            mac_addr, promisc, accept_multicast)) begin
                    passed = 1;
                    for (int k = 0; k < len; k++) begin
                        b.d = fr[k]; b.l = (k == len - 1); b.u = (k == len - 1) && fr_user;
                        exp_q.push_back(b);
                    end
                end
                @(posedge clock50); #1;
                if (!hs && ++cnt > 2000) begin
                    errors++;
                    $display("FAIL s_handshake_timeout got stalled expected accept");
                    s_axis_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        if (passed) mod_pass = sat(mod_pass);
        else begin
            mod_drop = sat(mod_drop);
            check("drop_always_ready", int'(stall), 0);
        end
    endtask

    task automatic drain_and_check(input string name);
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 5000) begin
            @(posedge clock50); #1;
            cnt++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge clock50);
        check({name, "_passed"}, int'(frames_passed), mod_pass);
        check({name, "_dropped"}, int'(frames_dropped), mod_drop);
        @(posedge clock50); #1;
    endtask

    task automatic rand_frame();
        logic [63:0] r;
        logic [47:0] dst;
        int len;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: dst = MAC;
            1: dst = BC;
            2: dst = {24'h01_00_5E, r[23:0]};
            3: dst = MAC2;
            default: dst = r[47:0];
        endcase
        len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
        build(dst, len, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        repeat (3) @(posedge clock50);
        @(negedge clock50);
        check("reset_m_tvalid", int'(m_axis_tvalid), 0);
        check("reset_s_tready", int'(s_axis_tready), 0);
        check("reset_m_tlast", int'(m_axis_tlast), 0);
        check("reset_m_tuser", int'(m_axis_tuser), 0);
        check("reset_passed", int'(frames_passed), 0);
        check("reset_dropped", int'(frames_dropped), 0);
        @(posedge clock50); #1;
        reset = 1'b0;
        @(posedge clock50); #1;

        build(MAC, 64, 1'b0);  send(0, 0, -1); drain_and_check("own_addr");
        build(MAC2, 64, 1'b0); send(0, 0, -1); drain_and_check("other_addr");
        build(BC, 20, 1'b0);   send(0, 0, -1); drain_and_check("bcast_am0");
        build(MC, 20, 1'b0);   send(0, 0, -1); drain_and_check("mcast_am0");
        accept_multicast = 1'b1;
        build(BC, 20, 1'b0);   send(0, 0, -1); drain_and_check("bcast_am1");
        build(MC, 20, 1'b0);   send(0, 0, -1); drain_and_check("mcast_am1");
        accept_multicast = 1'b0;
        build(MAC, 4, 1'b0);   send(0, 0, -1); drain_and_check("runt");
        build(MAC, 6, 1'b0);   send(0, 0, -1); drain_and_check("six_byte");

        ready_mode = 1;
        build(MAC, 100, 1'b1); send(0, 0, -1); drain_and_check("rand_ready_100");

        for (int n = 0; n < 30; n++) begin
            rand_frame(); send(1, 1, -1); drain_and_check("random");
        end
        // back-to-back frames, no drain between them
        for (int n = 0; n < 8; n++) begin
            rand_frame(); send(1, 0, -1);
        end
        drain_and_check("back_to_back");

        mac_addr = MAC; promisc = 1'b0; accept_multicast = 1'b0;
        for (int n = 0; n < 18; n++) begin
            build(MAC2, $urandom_range(1, 5), 1'b0); send(0, 0, -1);
        end
        drain_and_check("saturate");
        check("sat_dropped_allones", int'(frames_dropped), (1 << CW) - 1);

        build(MAC, 60, 1'b0); send(0, 0, 30);
        build(MAC, 40, 1'b1); send(0, 0, -1); drain_and_check("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/eth_rx_addr_filter.md
ETH_RX_ADDR_FILTER -- requirements
Module: eth_rx_addr_filter

Interface
REQ-001 SHALL have parameter: COUNT_WIDTH, 16, width of frame counters.
REQ-002 SHALL have one clock, clock50 (input, 1, 50 MHz), with all logic on its rising edge.
REQ-003 SHALL have reset (input, 1), synchronous and active-high.
REQ-004 SHALL have s_axis_tdata/tvalid/tlast/tuser (input, 8/1/1/1): receive byte stream from the Ethernet MAC RX FIFO.
REQ-005 SHALL have s_axis_tready (output, 1): upstream handshake.
REQ-006 SHALL have m_axis_tdata/tvalid/tlast/tuser (output, 8/1/1/1): filtered byte stream.
REQ-007 SHALL have m_axis_tready (input, 1): downstream handshake.
REQ-008 SHALL have mac_addr (input, 48): station address, with [47:40] the first byte on the wire.
REQ-009 SHALL have promisc (input, 1): pass all frames.
REQ-010 SHALL have accept_multicast (input, 1): pass group-addressed frames.
REQ-011 SHALL have frames_passed and frames_dropped (output, COUNT_WIDTH each): frame counters.

Function
REQ-012 SHALL treat a transfer as tvalid&&tready on either port and a frame as the bytes up to and including the one with tlast.
REQ-013 SHALL implement states HDR, FLUSH, PASS, DROP.
REQ-014 HDR: SHALL drive s_axis_tready=1 and m_axis_tvalid=0, store each accepted byte in a 6-byte buffer indexed 0..5, and keep the tlast/tuser of the last stored byte.
REQ-015 HDR: when byte index 5 is accepted, SHALL evaluate the match from buffer bytes 0..4 plus the current byte, using mac_addr/promisc/accept_multicast sampled in that same cycle.
REQ-016 Match SHALL be: promisc, OR dest==mac_addr, OR dest==FF:FF:FF:FF:FF:FF, OR (accept_multicast AND bit0 of byte0 ==1).
REQ-017 On match SHALL go to FLUSH; otherwise SHALL go to DROP, or straight to HDR if that byte carried tlast.
REQ-018 Runt: tlast accepted in HDR at index <5 SHALL end the frame with no output, increment frames_dropped, and return to HDR with index 0.
REQ-019 FLUSH: SHALL drive s_axis_tready=0 and present buffer bytes 0..5 in order with m_axis_tvalid=1, each held until m_axis_tready, with tlast=tuser=0 except on byte 5, which carries the stored tlast/tuser.
REQ-020 FLUSH exit: after byte 5 transfers, SHALL go to PASS, or to HDR (incrementing frames_passed) if the stored tlast=1.
REQ-021 PASS: SHALL drive m_axis_* = s_axis_* and s_axis_tready = m_axis_tready combinationally, adding zero latency.
REQ-022 PASS exit: on a tlast transfer SHALL increment frames_passed and go to HDR.
REQ-023 DROP: SHALL drive s_axis_tready=1 and m_axis_tvalid=0, discarding bytes.
REQ-024 DROP exit: on tlast SHALL increment frames_dropped and go to HDR.
REQ-025 Header latency: byte 0 SHALL appear on m_axis no earlier than the cycle after byte 5 is accepted, and every byte after byte 5 SHALL be passed through with zero latency.
REQ-026 tuser SHALL not affect filtering; a bad frame that passes SHALL be forwarded with its tuser intact.
REQ-027 Counters SHALL saturate at all-ones, not wrap.
REQ-028 Config input changes mid-frame SHALL affect only frames whose byte 5 has not yet been accepted.
REQ-029 Back-to-back frames SHALL be handled: the byte after tlast is byte 0 of the next frame, with no idle cycle required.

Reset
REQ-030 While reset=1: state=HDR, index=0, counters=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_tuser=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no counter update; after reset, the first byte accepted is treated as byte 0.

Verification
REQ-032 mac_addr=02:00:00:00:00:01, promisc=0, 64-byte frame to that address, m_axis_tready=1 -> identical 64 bytes out, tlast on byte 64, frames_passed=1.
REQ-033 Same config, 64-byte frame to 02:00:00:00:00:02 -> no m_axis_tvalid, s_axis_tready=1 throughout, frames_dropped=1.
REQ-034 Broadcast frame and 01:00:5E:00:00:01 frame with accept_multicast=0 -> broadcast passed, multicast dropped; repeat with accept_multicast=1 -> both passed.
REQ-035 4-byte runt with tlast, then a 6-byte matching frame -> runt dropped (frames_dropped=1), 6-byte frame output with tlast on byte 6 (frames_passed=1).
REQ-036 100-byte matching frame with m_axis_tready random at 50% -> output byte sequence identical, no duplicates or losses, tuser=1 on the input's last byte preserved.
REQ-037 Reset pulsed for 1 cycle at byte 30 of a passing frame -> m_axis_tvalid=0 and counters=0 the next cycle, and the next full frame is filtered correctly.
